// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two requesters.
// Outstanding read tags are queued in issue order to route returned beats.
module data_mem_arbiter #(
    parameter int DATA_MEM_READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] p0_address,
    input  logic [3:0]  p0_write_en,
    input  logic [31:0] p0_write_data,
    input  logic [3:0]  p0_read_en,
    output logic        p0_busy,
    output logic [31:0] p0_read_data,
    output logic        p0_read_data_valid,
    input  logic [31:0] p1_address,
    input  logic [3:0]  p1_write_en,
    input  logic [31:0] p1_write_data,
    input  logic [3:0]  p1_read_en,
    output logic        p1_busy,
    output logic [31:0] p1_read_data,
    output logic        p1_read_data_valid,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_write_en,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_read_en,
    input  logic [31:0] mem_read_data,
    input  logic        mem_read_data_valid,
    input  logic        mem_busy,
    output logic        protocol_error
);

    localparam int DEPTH = DATA_MEM_READ_LATENCY;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          last_grant;
    logic          tags [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic p0_wr, p1_wr, p0_req, p1_req;
    logic p0_elig, p1_elig, grant0, grant1;
    logic full, empty, push, pop, head;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign p0_wr  = |p0_write_en;
    assign p1_wr  = |p1_write_en;
    assign p0_req = p0_wr | (|p0_read_en);
    assign p1_req = p1_wr | (|p1_read_en);

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = mem_read_data_valid & ~empty;
    assign head  = tags[rd_ptr];

    // A read may issue into a full FIFO only when a return frees a slot now.
    assign p0_elig = p0_req & ~mem_busy & (p0_wr | ~full | pop);
    assign p1_elig = p1_req & ~mem_busy & (p1_wr | ~full | pop);

    assign grant0 = p0_elig & (~p1_elig | last_grant);
    assign grant1 = p1_elig & (~p0_elig | ~last_grant);

    assign push = (grant0 & ~p0_wr) | (grant1 & ~p1_wr);

    assign p0_busy = p0_req & ~grant0;
    assign p1_busy = p1_req & ~grant1;

    always_comb begin
        mem_address    = p0_address;
        mem_write_data = p0_write_data;
        mem_write_en   = '0;
        mem_read_en    = '0;
        if (grant0) begin
            mem_write_en = p0_write_en;
            mem_read_en  = p0_wr ? 4'b0000 : p0_read_en;
        end else if (grant1) begin
            mem_address    = p1_address;
            mem_write_data = p1_write_data;
            mem_write_en   = p1_write_en;
            mem_read_en    = p1_wr ? 4'b0000 : p1_read_en;
        end
    end

    assign p0_read_data       = mem_read_data;
    assign p1_read_data       = mem_read_data;
    assign p0_read_data_valid = pop & ~head;
    assign p1_read_data_valid = pop & head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant     <= 1'b1;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            protocol_error <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tags[i] <= 1'b0;
        end else begin
            if (grant0)
                last_grant <= 1'b0;
            else if (grant1)
                last_grant <= 1'b1;

            if (push) begin
                tags[wr_ptr] <= grant1;
                wr_ptr       <= ptr_next(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);

            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (mem_read_data_valid && empty)
                protocol_error <= 1'b1;
        end
    end

endmodule
